scan_decoder: RTL and testbench

Parametrised registered one-hot decoder: SEL_W-bit select drives a 2**SEL_W-bit one-hot output.

---
 rtl/scan_decoder_pkg.sv | 6 +
 rtl/scan_decoder_dwell_counter.sv | 24 ++
 rtl/scan_decoder.sv | 91 +++++++++
 tb/tb_scan_decoder.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg: shared state encoding and mode constants for the scan decoder.
package scan_decoder_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_DIRECT, ST_SCAN} state_e;
    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;
endpackage

// File: rtl/scan_decoder_dwell_counter.sv
// dwell_counter: loadable count-down timer; done_o is high while the count sits at zero.
module dwell_counter #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_i,
    input  logic               load_i,
    input  logic [DWELL_W-1:0] load_val_i,
    output logic               done_o
);
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = clr_i ? '0 : load_i ? load_val_i : (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);
endmodule

// File: rtl/scan_decoder.sv
// scan_decoder: registered one-hot decoder with a handshaked DIRECT mode
// and an autonomous SCAN mode that walks the outputs with a programmable dwell.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                mode,
    input  logic [SEL_W-1:0]    sel,
    input  logic                sel_vld,
    input  logic [DWELL_W-1:0]  dwell,
    output logic [(1<<SEL_W)-1:0] o,
    output logic                o_vld,
    output logic [SEL_W-1:0]    cur_idx,
    output logic                wrap
);
    localparam int OUT_W = 1 << SEL_W;

    state_e           state_q, state_d;
    logic [OUT_W-1:0] o_q, o_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             wrap_q, wrap_d;
    logic             cnt_clr, cnt_load, cnt_done;

    dwell_counter #(.DWELL_W(DWELL_W)) u_dwell (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (cnt_clr),
        .load_i     (cnt_load),
        .load_val_i (dwell),
        .done_o     (cnt_done)
    );

    always_comb begin
        state_d  = state_q;
        o_d      = o_q;
        idx_d    = idx_q;
        wrap_d   = 1'b0;
        cnt_clr  = 1'b0;
        cnt_load = 1'b0;
        if (!en) begin
            state_d = ST_IDLE;
            o_d     = '0;
            cnt_clr = 1'b1;
        end else if (mode == MODE_SCAN) begin
            // Entering SCAN from anywhere restarts at index 0; the dwell is sampled on each presentation.
            state_d = ST_SCAN;
            if (state_q != ST_SCAN) begin
                idx_d    = '0;
                o_d      = OUT_W'(1);
                cnt_load = 1'b1;
            end else if (cnt_done) begin
                idx_d    = idx_q + 1'b1;
                o_d      = OUT_W'(1) << (idx_q + 1'b1);
                wrap_d   = (idx_q == SEL_W'(OUT_W - 1));
                cnt_load = 1'b1;
            end
        end else begin
            state_d = ST_DIRECT;
            cnt_clr = 1'b1;
            o_d     = (state_q == ST_SCAN) ? '0 : o_q;
            if (sel_vld) begin
                o_d   = OUT_W'(1) << sel;
                idx_d = sel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            o_q     <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
        end
    end

    assign o       = o_q;
    assign o_vld   = |o_q;
    assign cur_idx = idx_q;
    assign wrap    = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder: directed stimulus, per-cycle model compare plus literal spot checks.
module tb_scan_decoder;
    logic       clk = 1'b0;
    logic       rst;
    logic       en = 1'b0, mode = 1'b0, sel_vld = 1'b0;
    logic [1:0] sel = '0;
    logic [7:0] dwell = '0;
    logic [3:0] o;
    logic       o_vld, wrap;
    logic [1:0] cur_idx;
    int total = 0, bad = 0;

    scan_decoder #(.SEL_W(2), .DWELL_W(8)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel), .sel_vld(sel_vld),
        .dwell(dwell), .o(o), .o_vld(o_vld), .cur_idx(cur_idx), .wrap(wrap)
    );

    always #5 clk = ~clk;

    // Behavioural model: which index is shown, whether anything is shown,
    // how long it has been shown and how long it must be shown.
    int  m_idx, m_age, m_hold;
    bit  m_on, m_scan, m_wrap;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idx = 0; m_on = 0; m_scan = 0; m_wrap = 0; m_age = 0; m_hold = 0;
        end else begin
            m_wrap = 0;
            if (!en) begin
                m_on = 0; m_scan = 0;
            end else if (mode) begin
                if (!m_scan) begin
                    m_scan = 1; m_idx = 0; m_on = 1; m_age = 1; m_hold = int'(dwell) + 1;
                end else if (m_age == m_hold) begin
                    m_wrap = (m_idx == 3);
                    m_idx = (m_idx + 1) % 4; m_age = 1; m_hold = int'(dwell) + 1;
                end else m_age++;
            end else begin
                if (m_scan) m_on = 0;
                m_scan = 0;
                if (sel_vld) begin
                    m_idx = int'(sel); m_on = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            chk("model_o", int'(o), m_on ? (1 << m_idx) : 0);
            chk("model_vld", int'(o_vld), int'(m_on));
            chk("model_idx", int'(cur_idx), m_idx);
            chk("model_wrap", int'(wrap), int'(m_wrap));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        #3;
        chk("rst_o", int'(o), 0);
        chk("rst_vld", int'(o_vld), 0);
        chk("rst_idx", int'(cur_idx), 0);
        chk("rst_wrap", int'(wrap), 0);
        cyc(2);
        rst = 1'b0;
        // DIRECT decode and hold
        en = 1; mode = 0; sel = 2; sel_vld = 1;
        cyc(1);
        chk("dir_o", int'(o), 4'b0100);
        chk("dir_idx", int'(cur_idx), 2);
        chk("dir_vld", int'(o_vld), 1);
        sel_vld = 0; sel = 1;
        cyc(2);
        chk("dir_hold", int'(o), 4'b0100);
        sel = 3;
        cyc(1);
        chk("dir_hold2", int'(o), 4'b0100);
        // SCAN dwell=0
        mode = 1; dwell = 0;
        cyc(1); chk("s0_a", int'(o), 4'b0001); chk("s0_wa", int'(wrap), 0);
        cyc(1); chk("s0_b", int'(o), 4'b0010);
        cyc(1); chk("s0_c", int'(o), 4'b0100);
        cyc(1); chk("s0_d", int'(o), 4'b1000); chk("s0_wd", int'(wrap), 0);
        cyc(1); chk("s0_e", int'(o), 4'b0001); chk("s0_we", int'(wrap), 1);
        cyc(1); chk("s0_f", int'(o), 4'b0010); chk("s0_wf", int'(wrap), 0);
        // SCAN dwell=2 with mid-hold change
        en = 0;
        cyc(1); chk("off_o", int'(o), 0);
        en = 1; dwell = 2;
        cyc(3); chk("s2_a", int'(o), 4'b0001);
        cyc(1); chk("s2_b", int'(o), 4'b0010);
        dwell = 0;
        cyc(2); chk("s2_b3", int'(o), 4'b0010);
        cyc(1); chk("s2_c", int'(o), 4'b0100);
        cyc(1); chk("s2_d", int'(o), 4'b1000);
        cyc(1); chk("s2_e", int'(o), 4'b0001); chk("s2_we", int'(wrap), 1);
        cyc(2); chk("s2_g", int'(o), 4'b0100);
        // en drop mid-scan
        en = 0;
        cyc(1);
        chk("drop_o", int'(o), 0);
        chk("drop_vld", int'(o_vld), 0);
        chk("drop_idx", int'(cur_idx), 2);
        en = 1;
        cyc(1); chk("restart_o", int'(o), 4'b0001);
        cyc(3); chk("pre_rst_o", int'(o), 4'b1000);
        // async reset between edges
        #2 rst = 1;
        #1;
        chk("arst_o", int'(o), 0);
        chk("arst_idx", int'(cur_idx), 0);
        chk("arst_wrap", int'(wrap), 0);
        mode = 0; sel = 1; sel_vld = 1;
        cyc(1);
        rst = 0;
        // mode wins over sel_vld
        cyc(1); chk("pri_dir", int'(o), 4'b0010);
        mode = 1; sel = 3; sel_vld = 1;
        cyc(1); chk("pri_scan", int'(o), 4'b0001); chk("pri_idx", int'(cur_idx), 0);
        // SCAN -> DIRECT blanks until sel_vld
        mode = 0; sel_vld = 0;
        cyc(1); chk("s2d_o", int'(o), 0); chk("s2d_vld", int'(o_vld), 0);
        sel_vld = 1; sel = 3;
        cyc(1); chk("s2d_dec", int'(o), 4'b1000);
        sel_vld = 0;
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
